// File: rtl/lc3_mem_responder_if.sv
// LC-3 single-port memory bus between the core (master) and the memory responder (slave).
interface lc3_mem_responder_if;
    logic [15:0] address;
    logic [15:0] dataToMemory;
    logic        writeEnable;
    logic [15:0] dataFromMemory;

    modport master (output address, output dataToMemory, output writeEnable, input dataFromMemory);
    modport slave  (input address, input dataToMemory, input writeEnable, output dataFromMemory);
endinterface

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: zero-latency RAM reads, clocked writes, and the KBSR/KBDR/DSR/DDR/MCR
// I/O page with keyboard and display FIFOs.
module lc3_mem_responder #(
    parameter int MEM_AW     = 16,
    parameter int KBD_DEPTH  = 4,
    parameter int DISP_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    lc3_mem_responder_if.slave       bus,
    input  logic                     kbd_valid,
    input  logic [7:0]               kbd_data,
    output logic                     kbd_ready,
    output logic                     disp_valid,
    output logic [7:0]               disp_data,
    input  logic                     disp_ready,
    output logic                     mcr_run
);
    localparam int KAW = $clog2(KBD_DEPTH);
    localparam int KCW = KAW + 1;
    localparam int DAW = $clog2(DISP_DEPTH);
    localparam int DCW = DAW + 1;
    localparam logic [KCW-1:0] KBD_FULL  = KCW'(KBD_DEPTH);
    localparam logic [DCW-1:0] DISP_FULL = DCW'(DISP_DEPTH);

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;
    localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

    logic [15:0] ram [2**MEM_AW];

    logic [7:0]     kbd_mem [KBD_DEPTH];
    logic [KAW-1:0] kbd_wp, kbd_rp;
    logic [KCW-1:0] kbd_count;

    logic [7:0]     disp_mem [DISP_DEPTH];
    logic [DAW-1:0] disp_wp, disp_rp;
    logic [DCW-1:0] disp_count;

    logic        kbdr_hit_q, ddr_hit_q, disp_ovf;
    logic [15:0] kbdr_q, mcr;

    logic        io_page, ram_we, mcr_we;
    logic        kbdr_rd, kbd_nonempty, kbd_push, kbd_pop;
    logic        ddr_wr, ddr_first, disp_push, disp_pop, disp_full_after_pop;
    logic [15:0] kbd_head_word, rd_data;

    assign io_page      = (bus.address[15:9] == 7'h7F);
    assign ram_we       = bus.writeEnable && !io_page;
    assign mcr_we       = bus.writeEnable && (bus.address == ADDR_MCR);

    assign kbd_nonempty  = (kbd_count != '0);
    assign kbd_ready     = (kbd_count < KBD_FULL);
    assign kbd_push      = kbd_valid && kbd_ready;
    assign kbdr_rd       = (bus.address == ADDR_KBDR) && !bus.writeEnable;
    assign kbd_pop       = kbdr_rd && !kbdr_hit_q && kbd_nonempty;
    assign kbd_head_word = kbd_nonempty ? {8'h00, kbd_mem[kbd_rp]} : '0;

    assign disp_valid = (disp_count != '0);
    assign disp_data  = disp_valid ? disp_mem[disp_rp] : '0;
    assign disp_pop   = disp_valid && disp_ready;
    assign ddr_wr     = bus.writeEnable && (bus.address == ADDR_DDR);
    assign ddr_first  = ddr_wr && !ddr_hit_q;
    // A same-cycle pop frees a slot, so fullness is judged after it.
    assign disp_full_after_pop = ((disp_count - DCW'(disp_pop)) == DISP_FULL);
    assign disp_push  = ddr_first && !disp_full_after_pop;

    assign mcr_run = mcr[15];

    always_comb begin
        rd_data = '0;
        if (!io_page) begin
            rd_data = ram[bus.address[MEM_AW-1:0]];
        end else begin
            case (bus.address)
                ADDR_KBSR: rd_data = {kbd_nonempty, 15'b0};
                // A held KBDR access keeps showing the character it popped on its first cycle.
                ADDR_KBDR: rd_data = kbdr_hit_q ? kbdr_q : kbd_head_word;
                ADDR_DSR:  rd_data = {(disp_count != DISP_FULL), 14'b0, disp_ovf};
                ADDR_MCR:  rd_data = mcr;
                default:   rd_data = '0;
            endcase
        end
    end
    assign bus.dataFromMemory = rd_data;

    // Storage arrays are not reset; RAM must survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) ram[bus.address[MEM_AW-1:0]] <= bus.dataToMemory;
        if (kbd_push) kbd_mem[kbd_wp] <= kbd_data;
        if (disp_push) disp_mem[disp_wp] <= bus.dataToMemory[7:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            kbd_wp     <= '0;
            kbd_rp     <= '0;
            kbd_count  <= '0;
            disp_wp    <= '0;
            disp_rp    <= '0;
            disp_count <= '0;
            kbdr_hit_q <= 1'b0;
            ddr_hit_q  <= 1'b0;
            kbdr_q     <= '0;
            disp_ovf   <= 1'b0;
            mcr        <= 16'h8000;
        end else begin
            kbdr_hit_q <= kbdr_rd;
            ddr_hit_q  <= ddr_wr;
            if (kbdr_rd && !kbdr_hit_q) kbdr_q <= kbd_head_word;

            if (kbd_push) kbd_wp <= kbd_wp + KAW'(1);
            if (kbd_pop)  kbd_rp <= kbd_rp + KAW'(1);
            kbd_count <= kbd_count + KCW'(kbd_push) - KCW'(kbd_pop);

            if (disp_push) disp_wp <= disp_wp + DAW'(1);
            if (disp_pop)  disp_rp <= disp_rp + DAW'(1);
            disp_count <= disp_count + DCW'(disp_push) - DCW'(disp_pop);
            if (ddr_first && disp_full_after_pop) disp_ovf <= 1'b1;

            if (mcr_we) mcr <= bus.dataToMemory;
        end
    end
endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed vector bench for lc3_mem_responder: per-cycle stimulus/expectation table plus latency sequences.
module tb_lc3_mem_responder;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       kbd_valid, kbd_ready, disp_valid, disp_ready, mcr_run;
    logic [7:0] kbd_data, disp_data;

    lc3_mem_responder_if bus ();

    lc3_mem_responder #(.MEM_AW(16), .KBD_DEPTH(4), .DISP_DEPTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .kbd_ready  (kbd_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready),
        .mcr_run    (mcr_run)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic        rst_n;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        we;
        logic        kv;
        logic [7:0]  kd;
        logic        dr;
        logic [15:0] e_dout;
        logic        e_kr;
        logic        e_dv;
        logic [7:0]  e_dd;
        logic        e_run;
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   failures = 0;

    function automatic void add(input logic c, input logic r, input logic [15:0] a, input logic [15:0] wd,
                                input logic w, input logic kv, input logic [7:0] kd, input logic dr,
                                input logic [15:0] ed, input logic ekr, input logic edv,
                                input logic [7:0] edd, input logic erun);
        vec_t v;
        v.chk = c; v.rst_n = r; v.addr = a; v.wdata = wd; v.we = w; v.kv = kv; v.kd = kd; v.dr = dr;
        v.e_dout = ed; v.e_kr = ekr; v.e_dv = edv; v.e_dd = edd; v.e_run = erun;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [26:0] got, exp;
        int          n;

        reset_n = 1'b0; bus.address = 16'hFE08; bus.dataToMemory = '0; bus.writeEnable = 1'b0;
        kbd_valid = 1'b0; kbd_data = '0; disp_ready = 1'b0;

        // chk rst  addr     wdata    we kv kd     dr  dout     kr dv dd     run
        add(0, 0, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 1);
        add(1, 0, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 1);
        // RAM: same-cycle write returns old data
        add(0, 1, 16'h3000, 16'h1234, 1, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 1);
        add(1, 1, 16'h3000, 16'hBEEF, 1, 0, 8'h00, 0, 16'h1234, 1, 0, 8'h00, 1);
        add(1, 1, 16'h3000, 16'h0000, 0, 0, 8'h00, 0, 16'hBEEF, 1, 0, 8'h00, 1);
        // MCR
        add(1, 1, 16'hFFFE, 16'h0000, 0, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h00, 1);
        add(1, 1, 16'hFFFE, 16'h0000, 1, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h00, 1);
        add(1, 1, 16'hFFFE, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0);
        // keyboard single char, held KBDR pops once
        add(1, 1, 16'hFE00, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE08, 16'h0000, 0, 1, 8'h41, 0, 16'h0000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE00, 16'h0000, 0, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 16'h0041, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 16'h0041, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 16'h0041, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE00, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0);
        // push into empty FIFO during a KBDR first access: not returned, not popped
        add(1, 1, 16'hFE02, 16'h0000, 0, 1, 8'h55, 0, 16'h0000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE00, 16'h0000, 0, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 16'h0055, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE00, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0);
        // five chars into a 4-deep FIFO
        add(1, 1, 16'hFE08, 16'h0000, 0, 1, 8'h61, 0, 16'h0000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE08, 16'h0000, 0, 1, 8'h62, 0, 16'h0000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE08, 16'h0000, 0, 1, 8'h63, 0, 16'h0000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE08, 16'h0000, 0, 1, 8'h64, 0, 16'h0000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE08, 16'h0000, 0, 1, 8'h65, 0, 16'h0000, 0, 0, 8'h00, 0);
        add(1, 1, 16'hFE00, 16'h0000, 0, 0, 8'h00, 0, 16'h8000, 0, 0, 8'h00, 0);
        add(1, 1, 16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 16'h0061, 0, 0, 8'h00, 0);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 16'h0062, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 16'h0063, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 16'h0064, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE00, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0);
        // display: held DDR write pushes once, fifth write overflows
        add(1, 1, 16'hFE04, 16'h0000, 0, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE06, 16'h0048, 1, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE06, 16'h0048, 1, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h48, 0);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h48, 0);
        add(1, 1, 16'hFE06, 16'h0049, 1, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h48, 0);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h48, 0);
        add(1, 1, 16'hFE06, 16'h004A, 1, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h48, 0);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h48, 0);
        add(1, 1, 16'hFE06, 16'h004B, 1, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h48, 0);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h48, 0);
        add(1, 1, 16'hFE06, 16'h004C, 1, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h48, 0);
        add(1, 1, 16'hFE04, 16'h0000, 0, 0, 8'h00, 0, 16'h0001, 1, 1, 8'h48, 0);
        add(1, 1, 16'hFE04, 16'h0000, 0, 0, 8'h00, 1, 16'h0001, 1, 1, 8'h48, 0);
        add(1, 1, 16'hFE04, 16'h0000, 0, 0, 8'h00, 1, 16'h8001, 1, 1, 8'h49, 0);
        add(1, 1, 16'hFE04, 16'h0000, 0, 0, 8'h00, 1, 16'h8001, 1, 1, 8'h4A, 0);
        add(1, 1, 16'hFE04, 16'h0000, 0, 0, 8'h00, 1, 16'h8001, 1, 1, 8'h4B, 0);
        add(1, 1, 16'hFE04, 16'h0000, 0, 0, 8'h00, 0, 16'h8001, 1, 0, 8'h00, 0);
        // two entries in each FIFO, then reset
        add(1, 1, 16'hFE08, 16'h0000, 0, 1, 8'h71, 0, 16'h0000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE08, 16'h0000, 0, 1, 8'h72, 0, 16'h0000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE06, 16'h0031, 1, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h31, 0);
        add(1, 1, 16'hFE06, 16'h0032, 1, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h31, 0);
        add(1, 1, 16'hFE00, 16'h0000, 0, 0, 8'h00, 0, 16'h8000, 1, 1, 8'h31, 0);
        add(1, 0, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h31, 0);
        add(1, 1, 16'hFE00, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 1);
        add(1, 1, 16'h3000, 16'h0000, 0, 0, 8'h00, 0, 16'hBEEF, 1, 0, 8'h00, 1);
        add(1, 1, 16'hFFFE, 16'h0000, 0, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h00, 1);
        // full display FIFO: pop and DDR push in the same cycle, no overflow
        add(1, 1, 16'hFE06, 16'h0051, 1, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 1);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h51, 1);
        add(1, 1, 16'hFE06, 16'h0052, 1, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h51, 1);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h51, 1);
        add(1, 1, 16'hFE06, 16'h0053, 1, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h51, 1);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h51, 1);
        add(1, 1, 16'hFE06, 16'h0054, 1, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h51, 1);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h51, 1);
        add(1, 1, 16'hFE06, 16'h0055, 1, 0, 8'h00, 1, 16'h0000, 1, 1, 8'h51, 1);
        add(1, 1, 16'hFE04, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h52, 1);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 1, 16'h0000, 1, 1, 8'h52, 1);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 1, 16'h0000, 1, 1, 8'h53, 1);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 1, 16'h0000, 1, 1, 8'h54, 1);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 1, 16'h0000, 1, 1, 8'h55, 1);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 1);
        // keyboard push and pop in the same cycle
        add(1, 1, 16'hFE08, 16'h0000, 0, 1, 8'h5A, 0, 16'h0000, 1, 0, 8'h00, 1);
        add(1, 1, 16'hFE02, 16'h0000, 0, 1, 8'h5B, 0, 16'h005A, 1, 0, 8'h00, 1);
        add(1, 1, 16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 1);
        add(1, 1, 16'hFE00, 16'h0000, 0, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h00, 1);
        add(1, 1, 16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 16'h005B, 1, 0, 8'h00, 1);
        add(1, 1, 16'hFE00, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 1);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset_n = vq[i].rst_n; bus.address = vq[i].addr; bus.dataToMemory = vq[i].wdata;
            bus.writeEnable = vq[i].we; kbd_valid = vq[i].kv; kbd_data = vq[i].kd; disp_ready = vq[i].dr;
            #1;
            if (vq[i].chk) begin
                tests++;
                got = {bus.dataFromMemory, kbd_ready, disp_valid, disp_data, mcr_run};
                exp = {vq[i].e_dout, vq[i].e_kr, vq[i].e_dv, vq[i].e_dd, vq[i].e_run};
                if (got !== exp) begin
                    failures++;
                    $display("FAIL vec%0d: got dout=%h kr=%b dv=%b dd=%h run=%b, expected dout=%h kr=%b dv=%b dd=%h run=%b",
                             i, bus.dataFromMemory, kbd_ready, disp_valid, disp_data, mcr_run,
                             vq[i].e_dout, vq[i].e_kr, vq[i].e_dv, vq[i].e_dd, vq[i].e_run);
                end
            end
        end

        // keyboard character to KBSR[15] in one cycle
        @(negedge clk);
        bus.address = 16'hFE08; bus.writeEnable = 1'b0; kbd_valid = 1'b1; kbd_data = 8'h77; disp_ready = 1'b0;
        @(negedge clk);
        kbd_valid = 1'b0; bus.address = 16'hFE00;
        #1 check("kbsr_latency", {16'h0, bus.dataFromMemory}, 32'h0000_8000);
        @(negedge clk);
        bus.address = 16'hFE02;
        #1 check("kbdr_latency", {16'h0, bus.dataFromMemory}, 32'h0000_0077);

        // DDR write to disp_valid in one cycle, then a bounded drain
        @(negedge clk);
        bus.address = 16'hFE06; bus.dataToMemory = 16'h0021; bus.writeEnable = 1'b1;
        #1 check("ddr_pre_valid", {31'h0, disp_valid}, 32'h0);
        @(negedge clk);
        bus.address = 16'hFE08; bus.writeEnable = 1'b0;
        #1 check("ddr_latency", {23'h0, disp_valid, disp_data}, {23'h0, 1'b1, 8'h21});
        disp_ready = 1'b1;
        n = 0;
        while (disp_valid && n < 8) begin
            @(negedge clk);
            #1 n++;
        end
        check("disp_drain_cycles", n, 1);
        disp_ready = 1'b0;

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
